// File: rtl/mem_port_arbiter_if.sv
// Memory bus between the port arbiter and a single-port 64-bit memory.
// Master drives request/address/data, slave returns ready/rdata/err.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              mem_valid;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_err;

  modport master (
    output mem_valid, mem_we, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata, mem_err
  );

  modport slave (
    input  mem_valid, mem_we, mem_addr, mem_wdata,
    output mem_ready, mem_rdata, mem_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Serialises fetch bursts and data accesses onto one memory port,
// with data priority, beat timeout and fetch squash.
module mem_port_arbiter #(
  parameter int ADDR_W   = 64,
  parameter int DATA_W   = 64,
  parameter int MAX_WAIT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                f_req,
  input  logic [ADDR_W-1:0]   f_addr,
  input  logic                f_abort,
  output logic [2*DATA_W-1:0] f_rdata,
  output logic                f_done,
  output logic                f_err,
  input  logic                m_req,
  input  logic                m_we,
  input  logic [ADDR_W-1:0]   m_addr,
  input  logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W-1:0]   m_rdata,
  output logic                m_done,
  output logic                m_err,
  output logic                f_stall,
  output logic                m_stall,
  mem_port_arbiter_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE, DATA, FETCH0, FETCH1, RESP
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_lo_q;
  logic [DATA_W-1:0] rdata_hi_q;
  logic              we_q;
  logic              sel_f_q;
  logic              abort_q;
  logic              err_q;
  logic [7:0]        wait_q;

  logic beat, hs, tmo, grant_m, grant_f, resp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    grant_m = 1'b0;
    grant_f = 1'b0;
    beat = (state_q == DATA) || (state_q == FETCH0)
        || (state_q == FETCH1);
    hs  = beat & bus.mem_ready;
    tmo = beat & ~bus.mem_ready
        & (wait_q == 8'(MAX_WAIT - 1));
    unique case (state_q)
      IDLE: begin
        if (m_req) begin
          grant_m = 1'b1;
          state_d = DATA;
        end else if (f_req) begin
          grant_f = 1'b1;
          state_d = FETCH0;
        end
      end
      DATA:   if (hs || tmo) state_d = RESP;
      FETCH0: begin
        // a faulted first beat ends the burst early
        if (hs && !bus.mem_err) state_d = FETCH1;
        else if (hs || tmo)     state_d = RESP;
      end
      FETCH1: if (hs || tmo) state_d = RESP;
      RESP:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_lo_q <= '0;
      rdata_hi_q <= '0;
      we_q       <= 1'b0;
      sel_f_q    <= 1'b0;
      abort_q    <= 1'b0;
      err_q      <= 1'b0;
      wait_q     <= '0;
    end else if (state_q == IDLE) begin
      abort_q <= grant_f & f_abort;
      if (grant_m || grant_f) begin
        addr_q     <= grant_m ? m_addr : f_addr;
        wdata_q    <= grant_m ? m_wdata : '0;
        we_q       <= grant_m & m_we;
        sel_f_q    <= grant_f;
        rdata_lo_q <= '0;
        rdata_hi_q <= '0;
        err_q      <= 1'b0;
        wait_q     <= '0;
      end
    end else begin
      if (sel_f_q && f_abort) abort_q <= 1'b1;
      if (beat) wait_q <= hs ? 8'd0 : wait_q + 8'd1;
      if (hs) begin
        if (state_q == FETCH1) rdata_hi_q <= bus.mem_rdata;
        else                   rdata_lo_q <= bus.mem_rdata;
        err_q <= err_q | bus.mem_err;
      end
      if (tmo) err_q <= 1'b1;
    end
  end

  assign resp = (state_q == RESP);

  assign bus.mem_valid = beat;
  assign bus.mem_we    = (state_q == DATA) & we_q;
  assign bus.mem_addr  = (state_q == FETCH1)
                       ? addr_q + ADDR_W'(8) : addr_q;
  assign bus.mem_wdata = wdata_q;

  assign m_done  = resp & ~sel_f_q;
  assign m_err   = m_done & err_q;
  assign m_rdata = rdata_lo_q;

  // a squash arriving in the response cycle still hides the result
  assign f_done  = resp & sel_f_q & ~abort_q & ~f_abort;
  assign f_err   = f_done & err_q;
  assign f_rdata = {rdata_hi_q, rdata_lo_q};

  assign f_stall = f_req & ~f_done;
  assign m_stall = m_req & ~m_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs change 1ns after
// the rising edge, outputs are sampled on the falling edge.
module tb_mem_port_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         f_req, f_abort, m_req, m_we;
  logic [63:0]  f_addr, m_addr, m_wdata;
  logic [127:0] f_rdata;
  logic [63:0]  m_rdata;
  logic         f_done, f_err, m_done, m_err;
  logic         f_stall, m_stall;
  int           checks = 0;
  int           failures = 0;

  mem_port_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus ();

  mem_port_arbiter #(
    .ADDR_W(64), .DATA_W(64), .MAX_WAIT(15)
  ) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_abort(f_abort),
    .f_rdata(f_rdata), .f_done(f_done), .f_err(f_err),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_rdata(m_rdata),
    .m_done(m_done), .m_err(m_err),
    .f_stall(f_stall), .m_stall(m_stall),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic edge_in();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    f_req = 0; f_abort = 0; m_req = 0; m_we = 0;
    f_addr = '0; m_addr = '0; m_wdata = '0;
    bus.mem_ready = 0; bus.mem_rdata = '0; bus.mem_err = 0;
    @(negedge clk);
    checks++;
    if ({bus.mem_valid, bus.mem_we, f_done, m_done, f_err, m_err} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl got %b exp 000000",
        {bus.mem_valid, bus.mem_we, f_done, m_done, f_err, m_err});
    end
    checks++;
    if ({f_rdata, m_rdata, bus.mem_addr} !== '0) begin
      failures++;
      $display("FAIL reset_regs got %h/%h/%h exp 0", f_rdata, m_rdata, bus.mem_addr);
    end
    @(negedge clk);
    rst = 1'b0;
    edge_in();
  endtask

  task automatic test_zero_wait_read();
    m_req = 1; m_we = 0; m_addr = 64'h40;
    bus.mem_ready = 1; bus.mem_rdata = 64'h1122; bus.mem_err = 0;
    @(negedge clk);
    checks++;
    if ({m_stall, bus.mem_valid} !== 2'b10) begin
      failures++;
      $display("FAIL rd_grant stall/valid got %b exp 10", {m_stall, bus.mem_valid});
    end
    edge_in();
    @(negedge clk);
    checks++;
    if ({bus.mem_valid, bus.mem_we, m_done, m_stall} !== 4'b1001
        || bus.mem_addr !== 64'h40) begin
      failures++;
      $display("FAIL rd_beat got v/we/done/stall=%b addr=%h exp 1001 40",
        {bus.mem_valid, bus.mem_we, m_done, m_stall}, bus.mem_addr);
    end
    edge_in();
    @(negedge clk);
    checks++;
    if ({bus.mem_valid, m_done, m_err, m_stall} !== 4'b0100
        || m_rdata !== 64'h1122) begin
      failures++;
      $display("FAIL rd_done got v/done/err/stall=%b rdata=%h exp 0100 1122",
        {bus.mem_valid, m_done, m_err, m_stall}, m_rdata);
    end
    edge_in();
    m_req = 0;
    @(negedge clk);
    checks++;
    if ({m_done, bus.mem_valid} !== 2'b00) begin
      failures++;
      $display("FAIL rd_idle got %b exp 00", {m_done, bus.mem_valid});
    end
  endtask

  task automatic test_fetch_burst();
    edge_in();
    f_req = 1; f_addr = 64'h100; bus.mem_ready = 1;
    bus.mem_rdata = 64'hA;
    edge_in();
    @(negedge clk);
    checks++;
    if (bus.mem_valid !== 1'b1 || bus.mem_addr !== 64'h100 || bus.mem_we !== 1'b0) begin
      failures++;
      $display("FAIL fetch_beat0 got v=%b addr=%h we=%b exp 1 100 0",
        bus.mem_valid, bus.mem_addr, bus.mem_we);
    end
    edge_in();
    bus.mem_rdata = 64'hB;
    @(negedge clk);
    checks++;
    if (bus.mem_valid !== 1'b1 || bus.mem_addr !== 64'h108 || f_done !== 1'b0) begin
      failures++;
      $display("FAIL fetch_beat1 got v=%b addr=%h done=%b exp 1 108 0",
        bus.mem_valid, bus.mem_addr, f_done);
    end
    edge_in();
    @(negedge clk);
    checks++;
    if ({f_done, f_err, f_stall, bus.mem_valid} !== 4'b1000
        || f_rdata !== {64'hB, 64'hA}) begin
      failures++;
      $display("FAIL fetch_done got d/e/s/v=%b rdata=%h exp 1000 b_a",
        {f_done, f_err, f_stall, bus.mem_valid}, f_rdata);
    end
    edge_in();
    f_req = 0;
  endtask

  task automatic test_contention();
    edge_in();
    m_req = 1; m_we = 1; m_addr = 64'h200; m_wdata = 64'hDEAD;
    f_req = 1; f_addr = 64'h300; bus.mem_ready = 1;
    edge_in();
    @(negedge clk);
    checks++;
    if ({bus.mem_valid, bus.mem_we} !== 2'b11 || bus.mem_addr !== 64'h200
        || bus.mem_wdata !== 64'hDEAD) begin
      failures++;
      $display("FAIL cont_data_first got v/we=%b addr=%h wd=%h exp 11 200 dead",
        {bus.mem_valid, bus.mem_we}, bus.mem_addr, bus.mem_wdata);
    end
    edge_in();
    @(negedge clk);
    checks++;
    if ({m_done, f_done, m_err} !== 3'b100) begin
      failures++;
      $display("FAIL cont_wr_done got m/f/err=%b exp 100", {m_done, f_done, m_err});
    end
    edge_in();
    m_req = 0; m_we = 0;
    edge_in();
    m_req = 1; m_addr = 64'h400;
    @(negedge clk);
    checks++;
    if (bus.mem_addr !== 64'h300 || bus.mem_we !== 1'b0) begin
      failures++;
      $display("FAIL cont_fetch_next got addr=%h we=%b exp 300 0",
        bus.mem_addr, bus.mem_we);
    end
    edge_in();
    @(negedge clk);
    checks++;
    if (bus.mem_addr !== 64'h308 || m_stall !== 1'b1) begin
      failures++;
      $display("FAIL cont_burst_atomic got addr=%h stall=%b exp 308 1",
        bus.mem_addr, m_stall);
    end
    edge_in();
    @(negedge clk);
    checks++;
    if ({f_done, m_done} !== 2'b10) begin
      failures++;
      $display("FAIL cont_fetch_done got f/m=%b exp 10", {f_done, m_done});
    end
    edge_in();
    f_req = 0;
    edge_in();
    @(negedge clk);
    checks++;
    if (bus.mem_addr !== 64'h400 || bus.mem_valid !== 1'b1) begin
      failures++;
      $display("FAIL cont_late_data got addr=%h v=%b exp 400 1",
        bus.mem_addr, bus.mem_valid);
    end
    edge_in();
    @(negedge clk);
    checks++;
    if (m_done !== 1'b1) begin
      failures++;
      $display("FAIL cont_late_done got %b exp 1", m_done);
    end
    edge_in();
    m_req = 0;
  endtask

  task automatic test_timeout();
    int vcnt;
    bit moved;
    vcnt = 0;
    moved = 0;
    edge_in();
    m_req = 1; m_we = 0; m_addr = 64'h500; bus.mem_ready = 0;
    edge_in();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!bus.mem_valid) break;
      vcnt++;
      if (bus.mem_addr !== 64'h500) moved = 1;
      edge_in();
    end
    checks++;
    if (vcnt != 15 || moved) begin
      failures++;
      $display("FAIL timeout_len got %0d cycles moved=%0d exp 15 0", vcnt, moved);
    end
    checks++;
    if ({m_done, m_err} !== 2'b11) begin
      failures++;
      $display("FAIL timeout_err got done/err=%b exp 11", {m_done, m_err});
    end
    edge_in();
    m_req = 0;
    bus.mem_ready = 1;
  endtask

  task automatic test_fault_wrap();
    edge_in();
    f_req = 1; f_addr = 64'h600; bus.mem_err = 1;
    bus.mem_rdata = 64'h77;
    edge_in();
    edge_in();
    bus.mem_err = 0;
    @(negedge clk);
    checks++;
    if ({bus.mem_valid, f_done, f_err} !== 3'b011
        || f_rdata !== {64'h0, 64'h77}) begin
      failures++;
      $display("FAIL fault_skip got v/d/e=%b rdata=%h exp 011 0_77",
        {bus.mem_valid, f_done, f_err}, f_rdata);
    end
    edge_in();
    f_req = 0;
    edge_in();
    f_req = 1; f_addr = 64'hFFFF_FFFF_FFFF_FFF8;
    edge_in();
    @(negedge clk);
    checks++;
    if (bus.mem_addr !== 64'hFFFF_FFFF_FFFF_FFF8) begin
      failures++;
      $display("FAIL wrap_beat0 got %h exp fffffffffffffff8", bus.mem_addr);
    end
    edge_in();
    @(negedge clk);
    checks++;
    if (bus.mem_addr !== 64'h0 || bus.mem_valid !== 1'b1) begin
      failures++;
      $display("FAIL wrap_beat1 got addr=%h v=%b exp 0 1", bus.mem_addr, bus.mem_valid);
    end
    edge_in();
    @(negedge clk);
    checks++;
    if ({f_done, f_err} !== 2'b10) begin
      failures++;
      $display("FAIL wrap_done got %b exp 10", {f_done, f_err});
    end
    edge_in();
    f_req = 0;
  endtask

  task automatic test_abort_reset();
    edge_in();
    f_req = 1; f_addr = 64'h700; bus.mem_ready = 1;
    edge_in();
    edge_in();
    f_abort = 1;
    @(negedge clk);
    checks++;
    if (bus.mem_valid !== 1'b1 || bus.mem_addr !== 64'h708) begin
      failures++;
      $display("FAIL abort_burst got v=%b addr=%h exp 1 708", bus.mem_valid, bus.mem_addr);
    end
    edge_in();
    f_abort = 0;
    @(negedge clk);
    checks++;
    if ({f_done, f_err, bus.mem_valid} !== 3'b000) begin
      failures++;
      $display("FAIL abort_no_done got %b exp 000", {f_done, f_err, bus.mem_valid});
    end
    edge_in();
    f_req = 0;
    edge_in();
    m_req = 1; m_addr = 64'h800; bus.mem_ready = 0;
    edge_in();
    @(negedge clk);
    checks++;
    if (bus.mem_valid !== 1'b1) begin
      failures++;
      $display("FAIL rst_pre got v=%b exp 1", bus.mem_valid);
    end
    #2;
    rst = 1;
    #1;
    checks++;
    if ({bus.mem_valid, m_done, m_err} !== 3'b000) begin
      failures++;
      $display("FAIL rst_async got v/d/e=%b exp 000", {bus.mem_valid, m_done, m_err});
    end
    edge_in();
    m_req = 0;
    rst = 0;
    @(negedge clk);
    edge_in();
    @(negedge clk);
    checks++;
    if ({bus.mem_valid, m_done} !== 2'b00) begin
      failures++;
      $display("FAIL rst_after got %b exp 00", {bus.mem_valid, m_done});
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait_read();
    test_fetch_burst();
    test_contention();
    test_timeout();
    test_fault_wrap();
    test_abort_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
